cordic_sequencer: RTL and testbench

- Control FSM that sequences the iterative CORDIC datapath from the memory-mapped control register.
- Decodes START/MODE/ITER/ABORT, issues load and per-iteration step strobes, and triggers result writeback.
- Writes status (BUSY/DONE/ERROR) back into the control register and raises an interrupt.
- Sits between the AXI-Lite register block (via the bus interface) and the CORDIC datapath.

---
 rtl/cordic_ctrl_pkg.sv | 26 ++
 rtl/cordic_sequencer_if.sv | 12 +
 rtl/cordic_sequencer.sv | 134 +++++++++++++
 tb/tb_cordic_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_ctrl_pkg.sv
// Shared definitions for the CORDIC control sequencer: control register
// bit map, FSM state type and default iteration limit.
package cordic_ctrl_pkg;

  localparam int START_BIT = 0;
  localparam int MODE_BIT  = 1;
  localparam int ITER_LSB  = 2;
  localparam int ITER_MSB  = 6;
  localparam int ABORT_BIT = 7;
  localparam int BUSY_BIT  = 8;
  localparam int DONE_BIT  = 9;
  localparam int ERROR_BIT = 10;
  localparam int IE_BIT    = 11;

  localparam int ITER_W       = ITER_MSB - ITER_LSB + 1;
  localparam int ITER_MAX_DEF = 24;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ITER,
    S_WB,
    S_FIN
  } seq_state_t;

endpackage

// File: rtl/cordic_sequencer_if.sv
// Control register bus between the AXI-Lite register block (master) and
// the sequencer (slave). ctrl_we overrides bus writes in the register block.
interface cordic_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] ctrl_in;
  logic [DATA_WIDTH-1:0] ctrl_out;
  logic                  ctrl_we;

  modport master (output ctrl_in, input ctrl_out, input ctrl_we);
  modport slave  (input ctrl_in, output ctrl_out, output ctrl_we);
endinterface

// File: rtl/cordic_sequencer.sv
// CORDIC control FSM: decodes the control register, strobes the datapath
// through load/iterate/writeback, and posts status back to the register.
module cordic_sequencer
  import cordic_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ITER_MAX   = ITER_MAX_DEF,
  parameter int IDX_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  cordic_sequencer_if.slave    bus,
  output logic                 dp_load,
  output logic                 dp_step,
  output logic                 dp_mode,
  output logic [IDX_WIDTH-1:0] iter_idx,
  output logic                 result_we,
  output logic                 irq
);

  seq_state_t            state_q, state_d;
  logic [IDX_WIDTH-1:0]  last_idx;
  logic                  err_q, abort_q;
  logic                  go_load, go_err, go_abort, adv_idx;
  logic [ITER_W-1:0]     cnt_in;
  logic [DATA_WIDTH-1:0] ctrl_v;

  assign cnt_in       = bus.ctrl_in[ITER_MSB:ITER_LSB];
  assign bus.ctrl_out = ctrl_v;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Run context: latched mode/limit, iteration counter, FIN flags, irq
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_mode  <= 1'b0;
      last_idx <= '0;
      iter_idx <= '0;
      err_q    <= 1'b0;
      abort_q  <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= bus.ctrl_in[DONE_BIT] & bus.ctrl_in[IE_BIT];
      if (go_load) begin
        dp_mode  <= bus.ctrl_in[MODE_BIT];
        last_idx <= IDX_WIDTH'(cnt_in - ITER_W'(1));
        iter_idx <= '0;
        err_q    <= 1'b0;
        abort_q  <= 1'b0;
      end
      if (go_err) begin
        err_q   <= 1'b1;
        abort_q <= 1'b0;
      end
      if (go_abort) begin
        err_q   <= 1'b1;
        abort_q <= 1'b1;
      end
      if (adv_idx) iter_idx <= iter_idx + IDX_WIDTH'(1);
    end
  end

  // Next state, strobes and control register write-back value
  always_comb begin
    state_d   = state_q;
    ctrl_v    = bus.ctrl_in;
    bus.ctrl_we = 1'b0;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    result_we = 1'b0;
    go_load   = 1'b0;
    go_err    = 1'b0;
    go_abort  = 1'b0;
    adv_idx   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ctrl_in[START_BIT] && !bus.ctrl_in[BUSY_BIT]) begin
          if (cnt_in == '0 || cnt_in > ITER_W'(ITER_MAX)) begin
            state_d = S_FIN;
            go_err  = 1'b1;
          end else begin
            state_d = S_LOAD;
            go_load = 1'b1;
          end
        end
      end
      S_LOAD: begin
        dp_load              = 1'b1;
        bus.ctrl_we          = 1'b1;
        ctrl_v[START_BIT]    = 1'b0;
        ctrl_v[BUSY_BIT]     = 1'b1;
        ctrl_v[DONE_BIT]     = 1'b0;
        ctrl_v[ERROR_BIT]    = 1'b0;
        if (bus.ctrl_in[ABORT_BIT]) begin
          state_d  = S_FIN;
          go_abort = 1'b1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        dp_step = 1'b1;
        if (bus.ctrl_in[ABORT_BIT]) begin
          state_d  = S_FIN;
          go_abort = 1'b1;
        end else if (iter_idx == last_idx) begin
          state_d = S_WB;
        end else begin
          adv_idx = 1'b1;
        end
      end
      S_WB: begin
        result_we = 1'b1;
        state_d   = S_FIN;
      end
      S_FIN: begin
        bus.ctrl_we       = 1'b1;
        ctrl_v[START_BIT] = 1'b0;
        ctrl_v[BUSY_BIT]  = 1'b0;
        ctrl_v[DONE_BIT]  = 1'b1;
        ctrl_v[ERROR_BIT] = err_q;
        if (abort_q) ctrl_v[ABORT_BIT] = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) ctrl_v = '0;
  end

endmodule

// File: tb/tb_cordic_sequencer.sv
// Randomized self-checking bench for cordic_sequencer. A small register
// block model closes the ctrl loop; expected traces come from the timing
// rules of a run (load, step, writeback, finish cycles) computed up front.
module tb_cordic_sequencer;
  import cordic_ctrl_pkg::*;

  localparam int DW   = 32;
  localparam int IMAX = 24;
  localparam int IW   = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dp_load, dp_step, dp_mode, result_we, irq;
  logic [IW-1:0] iter_idx;
  logic [DW-1:0] ctrl_reg;
  logic          sw_we = 1'b0;
  logic [DW-1:0] sw_data = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int idx_hold = 0;

  cordic_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  cordic_sequencer #(.DATA_WIDTH(DW), .ITER_MAX(IMAX), .IDX_WIDTH(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dp_load   (dp_load),
    .dp_step   (dp_step),
    .dp_mode   (dp_mode),
    .iter_idx  (iter_idx),
    .result_we (result_we),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  // Register block model: sequencer writes win over software writes
  assign bus.ctrl_in = ctrl_reg;
  always @(posedge clk) begin
    if (rst)              ctrl_reg <= '0;
    else if (bus.ctrl_we) ctrl_reg <= bus.ctrl_out;
    else if (sw_we)       ctrl_reg <= sw_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One software-started run. abort_cyc: cycle (START visible = 0) in which
  // ABORT first appears in the register; 0 = no abort.
  task automatic run_op(input int cnt, input bit mode, input bit ie, input int abort_cyc);
    logic [31:0] base, exp_word, exp_lw, fin_word, load_word;
    bit          valid, wb_abort, done;
    int          exp_steps, exp_fin, exp_wb, exp_err;
    int          n_load, load_cyc, n_wb, wb_cyc, n_fin, n_lw, fin_cyc, mode_bad, cyc;
    int          step_idx[$];
    int          step_cyc[$];

    base = $urandom();
    base[START_BIT] = 1'b1;
    base[BUSY_BIT]  = 1'b0;
    base[MODE_BIT]  = mode;
    base[ITER_MSB:ITER_LSB] = cnt[4:0];
    base[IE_BIT]    = ie;
    base[ABORT_BIT] = 1'b0;

    valid    = (cnt >= 1) && (cnt <= IMAX);
    wb_abort = 1'b0;
    exp_wb   = -1;
    if (!valid) begin
      exp_steps = 0; exp_fin = 1; exp_err = 1;
    end else if (abort_cyc == 1) begin
      exp_steps = 0; exp_fin = 2; exp_err = 1;
    end else if (abort_cyc >= 3 && abort_cyc <= cnt + 1) begin
      exp_steps = abort_cyc - 1; exp_fin = abort_cyc + 1; exp_err = 1;
    end else begin
      exp_steps = cnt; exp_wb = cnt + 2; exp_fin = cnt + 3; exp_err = 0;
      wb_abort  = (abort_cyc == cnt + 2);
    end
    exp_word = base;
    exp_word[START_BIT] = 1'b0;
    exp_word[BUSY_BIT]  = 1'b0;
    exp_word[DONE_BIT]  = 1'b1;
    exp_word[ERROR_BIT] = exp_err[0];
    exp_word[ABORT_BIT] = wb_abort;
    exp_lw = base;
    exp_lw[START_BIT] = 1'b0;
    exp_lw[BUSY_BIT]  = 1'b1;
    exp_lw[DONE_BIT]  = 1'b0;
    exp_lw[ERROR_BIT] = 1'b0;
    exp_lw[ABORT_BIT] = (abort_cyc == 1);

    @(negedge clk);
    sw_data = base; sw_we = 1'b1;
    @(negedge clk);
    sw_we = 1'b0;

    n_load = 0; load_cyc = -1; n_wb = 0; wb_cyc = -1; n_fin = 0; n_lw = 0;
    fin_cyc = -1; mode_bad = 0; cyc = 0; done = 1'b0;
    fin_word = '0; load_word = '0;
    while (!done && cyc < 80) begin
      if (dp_load) begin n_load++; load_cyc = cyc; end
      if (dp_step) begin
        step_idx.push_back(int'(iter_idx));
        step_cyc.push_back(cyc);
        if (dp_mode !== mode) mode_bad++;
      end
      if (result_we) begin n_wb++; wb_cyc = cyc; end
      if (bus.ctrl_we) begin
        if (bus.ctrl_out[DONE_BIT]) begin n_fin++; fin_cyc = cyc; fin_word = bus.ctrl_out; end
        else begin n_lw++; load_word = bus.ctrl_out; end
      end
      sw_we = 1'b0;
      if (cyc == abort_cyc - 1) begin
        sw_data = ctrl_reg; sw_data[ABORT_BIT] = 1'b1; sw_we = 1'b1;
      end
      if (fin_cyc >= 0 && cyc == fin_cyc + 1 && valid) check("irq_low", irq, 0);
      if (fin_cyc >= 0 && cyc == fin_cyc + 2) begin
        check("irq_set", irq, ie);
        sw_data = '0; sw_we = 1'b1;
      end
      if (fin_cyc >= 0 && cyc == fin_cyc + 4) begin
        check("irq_clr", irq, 0);
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    sw_we = 1'b0;

    check("run_done", done, 1);
    check("load_cnt", n_load, valid);
    check("load_wr_cnt", n_lw, valid);
    if (valid) begin
      check("load_cyc", load_cyc, 1);
      check("load_word", load_word, exp_lw);
      check("mode_hold", dp_mode, mode);
      idx_hold = (exp_steps > 0) ? exp_steps - 1 : 0;
    end
    check("step_cnt", step_idx.size(), exp_steps);
    for (int k = 0; k < step_idx.size() && k < exp_steps; k++) begin
      check("step_idx", step_idx[k], k);
      check("step_cyc", step_cyc[k], k + 2);
    end
    check("step_mode_bad", mode_bad, 0);
    check("wb_cnt", n_wb, (exp_wb >= 0));
    if (exp_wb >= 0) check("wb_cyc", wb_cyc, exp_wb);
    check("fin_cnt", n_fin, 1);
    check("fin_cyc", fin_cyc, exp_fin);
    check("fin_word", fin_word, exp_word);
    check("idx_hold", iter_idx, idx_hold);
  endtask

  // Reset during ITER abandons the run without any write-back
  task automatic reset_mid_run();
    logic [31:0] base;
    int          strobes;
    base = $urandom();
    base[START_BIT] = 1'b1;
    base[BUSY_BIT]  = 1'b0;
    base[ABORT_BIT] = 1'b0;
    base[ITER_MSB:ITER_LSB] = 5'd20;
    @(negedge clk);
    sw_data = base; sw_we = 1'b1;
    @(negedge clk);
    sw_we = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_pre_step", dp_step, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_load", dp_load, 0);
    check("rst_step", dp_step, 0);
    check("rst_wb", result_we, 0);
    check("rst_we", bus.ctrl_we, 0);
    check("rst_idx", iter_idx, 0);
    check("rst_ctrl_out", bus.ctrl_out, 0);
    rst = 1'b0;
    idx_hold = 0;
    strobes = 0;
    repeat (30) begin
      @(negedge clk);
      if (dp_load || dp_step || result_we || bus.ctrl_we) strobes++;
    end
    check("rst_quiet", strobes, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, sel, ac;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_load", dp_load, 0);
    check("reset_step", dp_step, 0);
    check("reset_wb", result_we, 0);
    check("reset_we", bus.ctrl_we, 0);
    check("reset_irq", irq, 0);
    check("reset_mode", dp_mode, 0);
    check("reset_idx", iter_idx, 0);
    check("reset_ctrl_out", bus.ctrl_out, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op(16, 1'b0, 1'b0, 0);
    run_op(0,  1'b0, 1'b1, 0);
    run_op(25, 1'b1, 1'b0, 0);
    run_op(24, 1'b1, 1'b1, 0);
    run_op(20, 1'b0, 1'b1, 7);
    run_op(10, 1'b1, 1'b0, 1);
    run_op(4,  1'b0, 1'b1, 6);
    run_op(1,  1'b1, 1'b1, 0);
    run_op(31, 1'b0, 1'b0, 0);
    reset_mid_run();
    run_op(12, 1'b1, 1'b1, 0);

    for (int r = 0; r < 25; r++) begin
      cnt = $urandom_range(0, 31);
      sel = $urandom_range(0, 3);
      ac  = 0;
      if (cnt >= 1 && cnt <= IMAX) begin
        if (sel == 1) ac = 1;
        else if (sel == 2 && cnt >= 2) ac = $urandom_range(3, cnt + 1);
        else if (sel == 3) ac = cnt + 2;
      end
      run_op(cnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ac);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
